// File: rtl/sdrc_bram_responder_pkg.sv
// sdrc_bram_responder_pkg: command codes, FSM states and address field widths shared by the responder.
package sdrc_bram_responder_pkg;
  localparam int BANK_W = 2;
  localparam int ROW_W = 11;
  localparam int COL_W = 8;
  localparam int DATA_W = 32;
  localparam int BE_W = DATA_W / 8;
  typedef enum logic [2:0] {
    CMD_NOP       = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVATE  = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101
  } cmd_e;
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACK,
    ST_WRITE_BURST,
    ST_READ_WAIT,
    ST_READ_BURST,
    ST_BUSY
  } state_e;
  function automatic logic is_cmd(input logic [2:0] c);
    return c inside {CMD_REFRESH, CMD_PRECHARGE, CMD_ACTIVATE, CMD_WRITE, CMD_READ};
  endfunction
endpackage

// File: rtl/sdrc_bram_responder_ram.sv
// sdrc_bram_responder_ram: byte-enabled word memory, one write port and one registered read port.
module sdrc_bram_responder_ram
  import sdrc_bram_responder_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++)
      if (i_we && i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
  end
  // Only the output register resets; the array keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sdrc_bram_responder.sv
// sdrc_bram_responder: SDRAM-controller user-side responder backed by block RAM with fixed timing.
// CasLatency must be at least 2 (one cycle is spent in the RAM read register).
module sdrc_bram_responder
  import sdrc_bram_responder_pkg::*;
#(
  parameter int MemAddressBitWidth = 12,
  parameter int InitCycles = 100,
  parameter int CasLatency = 2,
  parameter int CmdBusyCycles = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_sdrc_cmd_en,
  input  logic [2:0]  I_sdrc_cmd,
  input  logic        I_sdrc_precharge_ctrl,
  input  logic        I_sdram_power_down,
  input  logic        I_sdram_selfrefresh,
  input  logic [20:0] I_sdrc_addr,
  input  logic [3:0]  I_sdrc_dqm,
  input  logic [31:0] I_sdrc_data,
  input  logic [7:0]  I_sdrc_data_len,
  output logic [31:0] O_sdrc_data,
  output logic        O_sdrc_init_done,
  output logic        O_sdrc_cmd_ack
);
  localparam int IW = $clog2(InitCycles + 1);
  state_e r_state;
  cmd_e r_cmd;
  logic [IW-1:0] r_init_cnt;
  logic r_init_done;
  logic r_ack;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic w_we;
  logic w_re;
  logic [ROW_W+COL_W-1:0] w_rc;
  logic [MemAddressBitWidth-1:0] w_addr;
  logic w_unused;
  assign w_rc = {r_row, r_col};
  assign w_addr = w_rc[MemAddressBitWidth-1:0];
  assign w_we = r_state == ST_WRITE_BURST;
  // Reads are issued one cycle ahead of the word appearing on O_sdrc_data.
  assign w_re = (r_state == ST_READ_WAIT && r_cnt == '0) || (r_state == ST_READ_BURST && r_cnt != r_len);
  assign w_unused = &{1'b0, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
                      I_sdrc_addr[COL_W+ROW_W +: BANK_W], w_rc};
  assign O_sdrc_init_done = r_init_done;
  assign O_sdrc_cmd_ack = r_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cmd <= CMD_NOP;
      r_init_cnt <= '0;
      r_init_done <= 1'b0;
      r_ack <= 1'b0;
      r_row <= '0;
      r_col <= '0;
      r_len <= '0;
      r_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_INIT:
          if (r_init_cnt == IW'(InitCycles - 1)) begin
            r_init_done <= 1'b1;
            r_state <= ST_IDLE;
          end else r_init_cnt <= r_init_cnt + 1'b1;
        ST_IDLE:
          if (I_sdrc_cmd_en && is_cmd(I_sdrc_cmd)) begin
            r_cmd <= cmd_e'(I_sdrc_cmd);
            r_row <= I_sdrc_addr[COL_W +: ROW_W];
            r_col <= I_sdrc_addr[COL_W-1:0];
            r_len <= I_sdrc_data_len;
            r_ack <= 1'b1;
            r_state <= ST_ACK;
          end
        ST_ACK: begin
          r_cnt <= r_cmd == CMD_READ ? 8'(CasLatency - 2) : r_cmd == CMD_WRITE ? 8'd0 : 8'(CmdBusyCycles - 1);
          r_state <= r_cmd == CMD_WRITE ? ST_WRITE_BURST : r_cmd == CMD_READ ? ST_READ_WAIT : ST_BUSY;
        end
        ST_WRITE_BURST: begin
          r_col <= r_col + 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == r_len) r_state <= ST_IDLE;
        end
        ST_READ_WAIT:
          if (r_cnt == '0) begin
            r_col <= r_col + 1'b1;
            r_state <= ST_READ_BURST;
          end else r_cnt <= r_cnt - 1'b1;
        ST_READ_BURST:
          if (r_cnt == r_len) r_state <= ST_IDLE;
          else begin
            r_col <= r_col + 1'b1;
            r_cnt <= r_cnt + 1'b1;
          end
        ST_BUSY:
          if (r_cnt == '0) r_state <= ST_IDLE;
          else r_cnt <= r_cnt - 1'b1;
        default: r_state <= ST_INIT;
      endcase
    end
  end
  sdrc_bram_responder_ram #(.AW(MemAddressBitWidth)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_be    (~I_sdrc_dqm),
    .i_waddr (w_addr),
    .i_wdata (I_sdrc_data),
    .i_re    (w_re),
    .i_raddr (w_addr),
    .o_rdata (O_sdrc_data)
  );
endmodule
